// File: rtl/hw_solver_pkg.sv
// hw_solver_pkg: shared state encoding, counter width and result field positions for hw_solver.
package hw_solver_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int ITER_DEF = 16;
  localparam int ITER_W = $clog2(ITER_DEF + 1);
  localparam int ROOT_LSB = 0;
  localparam int REM_LSB = 16;
endpackage

// File: rtl/isqrt_core.sv
// isqrt_core: digit-by-digit integer square root, one root bit per enabled cycle.
// root/rem present the values after the current iteration so the caller can capture on last.
module isqrt_core
  import hw_solver_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER = DATA_W / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  output logic [ITER-1:0]   root,
  output logic [ITER+1:0]   rem,
  output logic              last
);
  logic [DATA_W-1:0] r_x;
  logic [ITER-1:0]   r_root;
  logic [ITER+1:0]   r_rem;
  logic [ITER_W-1:0] r_cnt;
  logic [ITER+2:0]   w_sh, w_trial, w_diff;
  logic              w_ge;
  // The live remainder never exceeds 2*root, so ITER+3 bits hold the shifted value exactly.
  assign w_sh = (ITER+3)'({r_rem, r_x[DATA_W-1 -: 2]});
  assign w_trial = (ITER+3)'({r_root, 2'b01});
  assign w_ge = w_sh >= w_trial;
  assign w_diff = w_ge ? w_sh - w_trial : w_sh;
  assign root = {r_root[ITER-2:0], w_ge};
  assign rem = (ITER+2)'(w_diff);
  assign last = r_cnt == ITER_W'(ITER - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_root <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_x <= x;
      r_root <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (en) begin
      r_x <= r_x << 2;
      r_root <= root;
      r_rem <= rem;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hw_solver.sv
// hw_solver: four-phase start/done responder returning isqrt(x) in result_export[15:0].
// Define HW_SOLVER_REM_EN to return the saturated remainder in result_export[31:16].
module hw_solver
  import hw_solver_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER = DATA_W / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_export,
  input  logic              start_export,
  output logic [31:0]       result_export,
  output logic              done_export
);
  state_t          r_state, w_next;
  logic [31:0]     r_result, w_result;
  logic [ITER-1:0] w_root;
  logic [ITER+1:0] w_rem;
  logic            w_last, w_load, w_calc;
  assign w_load = (r_state == IDLE) && start_export;
  assign w_calc = r_state == CALC;
  isqrt_core #(.DATA_W(DATA_W), .ITER(ITER)) u_core (
    .clk(clk), .reset(reset), .load(w_load), .en(w_calc), .x(x_export),
    .root(w_root), .rem(w_rem), .last(w_last)
  );
  // DONE only exits on a sampled-low start, so a held start cannot retrigger.
  always_comb begin
    w_next = r_state == IDLE ? (start_export ? CALC : IDLE) :
             r_state == CALC ? (w_last ? DONE : CALC) :
             (start_export ? DONE : IDLE);
  end
`ifdef HW_SOLVER_REM_EN
  always_comb begin
    w_result = '0;
    w_result[ROOT_LSB +: 16] = 16'(w_root);
    w_result[REM_LSB +: 16] = |w_rem[ITER+1:16] ? 16'hFFFF : w_rem[15:0];
  end
`else
  logic w_unused;
  assign w_unused = ^w_rem;
  always_comb begin
    w_result = '0;
    w_result[ROOT_LSB +: 16] = 16'(w_root);
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_calc && w_last) r_result <= w_result;
    end
  end
  assign done_export = r_state == DONE;
  assign result_export = r_result;
endmodule

// File: tb/tb_hw_solver.sv
// tb_hw_solver: directed checks of hw_solver results, latency and four-phase handshake.
module tb_hw_solver;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] x_export = '0;
  logic        start_export = 0;
  logic [31:0] result_export;
  logic        done_export;
  int          checks = 0;
  int          errors = 0;

  hw_solver dut (
    .clk(clk), .reset(reset), .x_export(x_export), .start_export(start_export),
    .result_export(result_export), .done_export(done_export)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expv(input int root, input int rem);
    logic [31:0] r;
    logic [31:0] m;
    r = root;
    m = rem;
`ifdef HW_SOLVER_REM_EN
    return {(rem > 65535) ? 16'hFFFF : m[15:0], r[15:0]};
`else
    return {16'h0, r[15:0]};
`endif
  endfunction

  task automatic run(input logic [31:0] x, input int root, input int rem);
    @(negedge clk);
    x_export = x;
    start_export = 1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("busy_done", {31'b0, done_export}, 32'd0);
      if (j == 0) x_export = ~x;
    end
    @(negedge clk);
    chk("done_at_16", {31'b0, done_export}, 32'd1);
    chk("result", result_export, expv(root, rem));
    start_export = 0;
    @(negedge clk);
    chk("done_clear", {31'b0, done_export}, 32'd0);
    chk("result_hold", result_export, expv(root, rem));
  endtask

  initial begin
    int hi;
    int first;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, done_export}, 32'd0);
    chk("rst_result", result_export, 32'd0);
    reset = 0;
    run(32'd0, 0, 0);
    run(32'd17, 4, 1);
    run(32'd1000000, 1000, 0);
    run(32'hFFFFFFFF, 65535, 131070);
    // start held high for 40 cycles
    @(negedge clk);
    x_export = 32'd1000000;
    start_export = 1;
    hi = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      hi += int'(done_export);
    end
    chk("hold_done_cycles", hi, 32'd24);
    chk("hold_done", {31'b0, done_export}, 32'd1);
    chk("hold_result", result_export, expv(1000, 0));
    start_export = 0;
    @(negedge clk);
    chk("hold_clear", {31'b0, done_export}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_done", {31'b0, done_export}, 32'd0);
    // single-cycle start pulse
    x_export = 32'd17;
    start_export = 1;
    @(negedge clk);
    start_export = 0;
    hi = 0;
    first = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (done_export) begin
        hi++;
        if (first < 0) first = j;
      end
    end
    chk("pulse_done_cycles", hi, 32'd1);
    chk("pulse_done_edge", first, 32'd16);
    chk("pulse_result", result_export, expv(4, 1));
    // reset during iteration 8
    @(negedge clk);
    x_export = 32'd99;
    start_export = 1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1;
    start_export = 0;
    @(negedge clk);
    chk("abort_done", {31'b0, done_export}, 32'd0);
    chk("abort_result", result_export, 32'd0);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_stale", {31'b0, done_export}, 32'd0);
    run(32'd99, 9, 18);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
